// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states,
// byte-lane geometry and small address helpers.
// Optional feature macro: LSU_MISALIGN_CHECK_EN (see load_store_unit.sv).
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} lsu_state_t;

  // The reserved encoding 2'b11 behaves exactly like a word access.
  function automatic logic [1:0] normSize(input logic [1:0] size);
    return (size == 2'b11) ? SIZE_W : size;
  endfunction

  // Halfwords must be even, words must sit on a 4-byte boundary.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
    return ((size == SIZE_H) && offset[0]) || ((size == SIZE_W) && (offset != 2'b00));
  endfunction

  // Clears the address bits below the access size (used when no check is done).
  function automatic logic [1:0] alignOffset(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_B:  return offset;
      SIZE_H:  return {offset[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane datapath: load extraction with sign/zero
// extension, and the read-modify-write merge for sub-word stores.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] loadWord,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        isUnsigned,
  input  logic [31:0] oldWord,
  input  logic [31:0] newData,
  output logic [31:0] loadData,
  output logic [31:0] mergedWord
);

  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  assign byteVal = loadWord[{offset, 3'b000} +: LANE_W];
  assign halfVal = offset[1] ? loadWord[31:16] : loadWord[15:0];

  // Extend the selected lane to a full word according to size and signedness.
  always_comb begin
    loadData = loadWord;
    case (size)
      SIZE_B:  loadData = {{24{~isUnsigned & byteVal[7]}}, byteVal};
      SIZE_H:  loadData = {{16{~isUnsigned & halfVal[15]}}, halfVal};
      default: loadData = loadWord;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : gLane
      localparam logic [1:0] LANE_IDX = 2'(gi);
      logic       laneSel;
      logic [7:0] laneNew;

      // Decide whether this lane takes store data, and which store byte feeds it.
      always_comb begin
        laneSel = 1'b1;
        laneNew = newData[gi*LANE_W +: LANE_W];
        case (size)
          SIZE_B: begin
            laneSel = (offset == LANE_IDX);
            laneNew = newData[7:0];
          end
          SIZE_H: begin
            laneSel = (offset[1] == LANE_IDX[1]);
            laneNew = newData[(gi % 2)*LANE_W +: LANE_W];
          end
          default: begin
            laneSel = 1'b1;
            laneNew = newData[gi*LANE_W +: LANE_W];
          end
        endcase
      end

      assign mergedWord[gi*LANE_W +: LANE_W] = laneSel ? laneNew : oldWord[gi*LANE_W +: LANE_W];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: valid/ready request side towards the core, aligned
// word-addressed port towards data memory. Sub-word stores use a
// read (ACCESS) then merged write (MERGE).
// Optional feature macro: LSU_MISALIGN_CHECK_EN -- when defined, misaligned
// requests complete with resp_err=1 and never touch memory; when undefined,
// low address bits below the access size are simply dropped.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic [N-1:0] resp_rdata,
  output logic         resp_err,
  output logic [N-1:0] mem_adr,
  output logic [N-1:0] mem_wdata,
  output logic         mem_write,
  input  logic [N-1:0] mem_rdata
);

  lsu_state_t   stateReg, stateNext;
  logic [N-1:0] addrReg, wdataReg, oldReg, rdataReg;
  logic [1:0]   sizeReg;
  logic         unsignedReg, writeReg;
  logic [1:0]   reqSize, reqOffset;
  logic         reqMisaligned;
  logic [N-1:0] loadData, mergedWord;
  logic         accept;

  assign reqSize = normSize(req_size);
  assign accept  = (stateReg == IDLE) && req_valid;

`ifdef LSU_MISALIGN_CHECK_EN
  logic errReg;
  assign reqMisaligned = isMisaligned(reqSize, req_addr[1:0]);
  assign reqOffset     = req_addr[1:0];
  assign resp_err      = errReg && (stateReg == RESP);
`else
  assign reqMisaligned = 1'b0;
  assign reqOffset     = alignOffset(reqSize, req_addr[1:0]);
  assign resp_err      = 1'b0;
`endif

  assign mem_adr    = {addrReg[N-1:2], 2'b00};
  assign resp_rdata = rdataReg;

  lsu_byte_lane uLane (
    .loadWord   (mem_rdata),
    .offset     (addrReg[1:0]),
    .size       (sizeReg),
    .isUnsigned (unsignedReg),
    .oldWord    (oldReg),
    .newData    (wdataReg),
    .loadData   (loadData),
    .mergedWord (mergedWord)
  );

  // State and request latches; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg    <= IDLE;
      addrReg     <= '0;
      wdataReg    <= '0;
      oldReg      <= '0;
      rdataReg    <= '0;
      sizeReg     <= SIZE_B;
      unsignedReg <= 1'b0;
      writeReg    <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
      errReg      <= 1'b0;
`endif
    end else begin
      stateReg <= stateNext;
      if (accept) begin
        addrReg     <= {req_addr[N-1:2], reqOffset};
        wdataReg    <= req_wdata;
        sizeReg     <= reqSize;
        unsignedReg <= req_unsigned;
        writeReg    <= req_write;
        rdataReg    <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
        errReg      <= reqMisaligned;
`endif
      end else if (stateReg == ACCESS) begin
        if (!writeReg) begin
          rdataReg <= loadData;
        end else if (sizeReg != SIZE_W) begin
          oldReg <= mem_rdata;
        end
      end
    end
  end

  // Next-state and state-decoded outputs; memory strobes depend only on registers.
  always_comb begin
    stateNext  = stateReg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_write  = 1'b0;
    mem_wdata  = '0;
    case (stateReg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          stateNext = reqMisaligned ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (writeReg && (sizeReg == SIZE_W)) begin
          mem_write = 1'b1;
          mem_wdata = wdataReg;
          stateNext = RESP;
        end else if (writeReg) begin
          stateNext = MERGE;
        end else begin
          stateNext = RESP;
        end
      end
      MERGE: begin
        mem_write = 1'b1;
        mem_wdata = mergedWord;
        stateNext = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        stateNext  = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the word-wide data memory port. Accepts byte, halfword and word load/store requests from the core over a valid/ready handshake.
- Drives the aligned word-addressed memory interface: combinational read, write on posedge clk.
- Performs byte-lane extraction and sign/zero extension for loads, and read-modify-write for sub-word stores.
- Sits between the execute/memory stage and the data memory in the multi-cycle datapath.

Parameters:
- N, 32, data and address width; must be 32 (byte-lane logic is fixed at 4 lanes).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  access size: SIZE_B, SIZE_H, SIZE_W.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  N  byte address.
- req_wdata  in  N  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  N  extended load result; 0 for stores and errors.
- resp_err  out  1  misaligned access; valid with resp_valid.
- mem_adr  out  N  word-aligned address, {addr_q[N-1:2], 2'b00}.
- mem_wdata  out  N  word to write.
- mem_write  out  1  write strobe; memory commits on the next posedge clk.
- mem_rdata  in  N  combinational read word, little-endian.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - resp_valid=0, resp_err=0, resp_rdata=0, mem_write=0.
  - mem_adr=0, mem_wdata=0, all request latches 0.
  - Reset mid-transaction abandons the access; no partial write is issued afterwards.
- FSM states: IDLE, ACCESS, MERGE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready at posedge, latch addr/size/unsigned/write/wdata.
  - Misaligned request → RESP. Otherwise → ACCESS.
  - Misaligned means: half with addr[0]=1, or word with addr[1:0]≠0.
- ACCESS:
  - mem_adr is driven from the latched address.
  - Load: extract lane addr[1:0] (byte) or addr[1] (half) from mem_rdata, extend, register into resp_rdata → RESP.
  - Word store: mem_write=1 and mem_wdata=wdata_q this cycle → RESP.
  - Sub-word store: capture mem_rdata into old_q → MERGE.
- MERGE:
  - mem_write=1.
  - mem_wdata = old_q with the selected byte/half lane replaced by the low bits of wdata_q → RESP.
- RESP: resp_valid=1 for exactly one cycle, then → IDLE. req_ready=0 in every state except IDLE.
- Latency from the accept edge to resp_valid:
  - load or word store: 2 cycles;
  - sub-word store: 3 cycles;
  - misaligned: 1 cycle.
- A misaligned access never asserts mem_write.
- Lane selection: byte lane k is bits [8k+7:8k]; half lane uses addr[1].
- Back-to-back requests: the next accept can happen in the cycle after RESP, so minimum issue interval is 3 cycles.
- req_size=2'b11 is reserved and treated as SIZE_W.
- mem_write is registered-state decoded, so it is glitch-free with respect to req_* inputs.

Optional Feature:
- LSU_MISALIGN_CHECK_EN defined: misaligned requests complete with resp_err=1, resp_rdata=0 and no memory access.
- LSU_MISALIGN_CHECK_EN undefined:
  - No alignment check.
  - Low address bits below the access size are forced to 0; word access uses lane 0.
  - resp_err is tied to 0.

Decomposition:
- Package lsu_pkg:
  - SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10;
  - state enum lsu_state_t {IDLE, ACCESS, MERGE, RESP};
  - lane width constant 8.
- One combinational sub-module, lsu_byte_lane:
  - load extract/extend: inputs word, offset, size, unsigned;
  - store merge: inputs old word, new data, offset, size.
- The FSM and registers stay in load_store_unit.

Test Plan:
- Memory word 0x80F1_7F02 at 0x1000; load byte signed at 0x1003 → resp_rdata=0xFFFF_FF80, resp_valid 2 cycles after accept, mem_write never 1.
- Same word, load half unsigned at 0x1002 → 0x0000_80F1; signed → 0xFFFF_80F1.
- Memory word 0x1122_3344 at 0x2000; store byte 0xAB at 0x2001 → exactly one mem_write cycle (in MERGE) with mem_wdata=0x1122_AB44; resp_valid 3 cycles after accept.
- Store word 0xDEAD_BEEF at 0x2004 → mem_write in ACCESS, memory holds 0xDEAD_BEEF; read-back load word returns it.
- With LSU_MISALIGN_CHECK_EN: load word at 0x2002 → resp_err=1, resp_rdata=0 one cycle after accept, no mem_write. Without the macro: returns the word at 0x2000, resp_err=0.
- Assert rst_n=0 during MERGE of a store half → mem_write=0 immediately, memory unchanged, req_ready=1 after release.
